// File: rtl/io_confirm_input_ctrl_pkg.sv
// Shared IO-space definitions for the switch input port: addresses, format codes,
// FSM state encoding and the switch formatting helper.
`timescale 1ns/1ps
package io_pkg;

  localparam logic [31:0] SW16_ADDR  = 32'hFFFF_FFF1;
  localparam logic [31:0] SW8S_ADDR  = 32'hFFFF_FFF3;
  localparam logic [31:0] SW8U_ADDR  = 32'hFFFF_FFF5;
  localparam logic [31:0] SW3_ADDR   = 32'hFFFF_FFF7;
  localparam logic [31:0] SWLO_ADDR  = 32'hFFFF_FFF9;
  localparam logic [31:0] SWRAW_ADDR = 32'hFFFF_FFFB;

  // Format codes are the low nibble of the confirm-class addresses.
  localparam logic [3:0] FMT_SW16 = 4'h1;
  localparam logic [3:0] FMT_SW8S = 4'h3;
  localparam logic [3:0] FMT_SW8U = 4'h5;
  localparam logic [3:0] FMT_SW3  = 4'h7;
  localparam logic [3:0] FMT_SWLO = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_RESP         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_e;

  function automatic logic is_confirm_addr(input logic [31:0] addr);
    return (addr == SW16_ADDR) || (addr == SW8S_ADDR) || (addr == SW8U_ADDR) ||
           (addr == SW3_ADDR)  || (addr == SWLO_ADDR);
  endfunction

  function automatic logic [31:0] format_sw(input logic [3:0] code, input logic [15:0] sw);
    logic [31:0] res;
    res = '0;
    case (code)
      FMT_SW16: res = {16'h0000, sw};
      FMT_SW8S: res = {{24{sw[15]}}, sw[15:8]};
      FMT_SW8U: res = {24'h00_0000, sw[15:8]};
      FMT_SW3:  res = {29'h0, sw[2:0]};
      FMT_SWLO: res = {24'h00_0000, sw[7:0]};
      default:  res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/io_confirm_input_ctrl_btn_debounce.sv
// Confirm button conditioning: 2-flop synchroniser, stability counter,
// stable level output and a one-cycle pulse on each accepted release-to-press edge.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_lvl,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

  logic            btn_meta;
  logic            btn_sync;
  logic [DB_W-1:0] cnt;
  logic            lvl;
  logic            press_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
    end
  end

  // press is registered on the same edge that flips the stable level high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt     <= '0;
      lvl     <= 1'b0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (btn_sync == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt     <= '0;
        lvl     <= btn_sync;
        press_q <= btn_sync;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  assign btn_lvl = lvl;
  assign press   = press_q;

endmodule

// File: rtl/io_confirm_input_ctrl.sv
// Switch input port load sequencer: confirm-class loads stall until a debounced
// button press, direct-class loads return the synchronised switches immediately.
`timescale 1ns/1ps
module io_confirm_input_ctrl
  import io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000,
  parameter int unsigned DB_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_rd,
  input  logic [31:0] address,
  input  logic [15:0] switch_input,
  input  logic        confirm_btn,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        wait_led
);

  state_e      state;
  state_e      state_n;
  logic [15:0] sw_meta;
  logic [15:0] sw_s;
  logic [3:0]  fmt_q;
  logic [31:0] rd_data_q;
  logic        wait_led_q;
  logic        btn_lvl;
  logic        press;
  logic        confirm_addr;
  logic        direct_rd;
  logic [31:0] direct_data;
  logic        latch_fmt;
  logic        capture;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (confirm_btn),
    .btn_lvl (btn_lvl),
    .press   (press)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= switch_input;
      sw_s    <= sw_meta;
    end
  end

  assign confirm_addr = is_confirm_addr(address);
  assign direct_data  = (address == SWRAW_ADDR) ? {16'h0000, sw_s} : '0;

  always_comb begin
    state_n   = state;
    latch_fmt = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (io_rd && confirm_addr) begin
          state_n   = ST_WAIT_PRESS;
          latch_fmt = 1'b1;
        end
      end
      // A pipeline flush outranks a press arriving in the same cycle.
      ST_WAIT_PRESS: begin
        if (!io_rd) begin
          state_n = ST_IDLE;
        end else if (press) begin
          state_n = ST_RESP;
          capture = 1'b1;
        end
      end
      ST_RESP: begin
        state_n = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (!btn_lvl) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      fmt_q      <= '0;
      rd_data_q  <= '0;
      wait_led_q <= 1'b0;
    end else begin
      state      <= state_n;
      wait_led_q <= (state_n == ST_WAIT_PRESS);
      if (latch_fmt) begin
        fmt_q <= address[3:0];
      end
      if (capture) begin
        rd_data_q <= format_sw(fmt_q, sw_s);
      end
    end
  end

  // Direct reads bypass the captured register only while the FSM is idle.
  assign direct_rd = rst && io_rd && !confirm_addr && (state == ST_IDLE);
  assign stall     = rst && io_rd && confirm_addr && (state != ST_RESP);
  assign rd_valid  = direct_rd || (rst && (state == ST_RESP));
  assign rd_data   = direct_rd ? direct_data : rd_data_q;
  assign wait_led  = wait_led_q;

endmodule

// File: tb/tb_io_confirm_input_ctrl.sv
// Scoreboard bench for io_confirm_input_ctrl with a short debounce window.
`timescale 1ns/1ps
module tb_io_confirm_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_rd;
  logic [31:0] address;
  logic [15:0] switch_input;
  logic        confirm_btn;
  logic        stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wait_led;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned valid_cnt = 0;
  logic [31:0] exp_q[$];

  io_confirm_input_ctrl #(
    .DB_CYCLES (4),
    .DB_W      (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_rd        (io_rd),
    .address      (address),
    .switch_input (switch_input),
    .confirm_btn  (confirm_btn),
    .stall        (stall),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wait_led     (wait_led)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every valid load pops the oldest expected value.
  always @(negedge clk) begin
    if (rst === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'd1, 32'd0);
      end else begin
        check_eq("rd_data", rd_data, exp_q.pop_front());
      end
      valid_cnt++;
    end
  end

  task automatic wait_valid(input string tag, input int unsigned budget);
    int unsigned start;
    int unsigned nostall;
    logic        got;
    start   = valid_cnt;
    nostall = 0;
    got     = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (valid_cnt != start) begin
        got = 1'b1;
        break;
      end
      if (stall !== 1'b1) nostall++;
    end
    check_eq({tag, "_done"}, 32'(got), 32'd1);
    check_eq({tag, "_stall_held"}, nostall, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned start;
    rst          = 1'b0;
    io_rd        = 1'b1;
    address      = 32'hFFFF_FFF1;
    switch_input = '0;
    confirm_btn  = 1'b0;

    // Reset with a pending confirm load
    repeat (3) step();
    @(negedge clk);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_data", rd_data, 32'd0);
    check_eq("rst_led", 32'(wait_led), 32'd0);
    step();
    rst   = 1'b1;
    io_rd = 1'b0;

    // Direct loads
    switch_input = 16'hA5C3;
    repeat (3) step();
    io_rd   = 1'b1;
    address = 32'hFFFF_FFFB;
    exp_q.push_back(32'h0000_A5C3);
    start = valid_cnt;
    @(negedge clk);
    #1;
    check_eq("direct_valid", valid_cnt, start + 1);
    check_eq("direct_stall", 32'(stall), 32'd0);
    step();
    address = 32'h0000_1000;
    exp_q.push_back(32'h0);
    @(negedge clk);
    #1;
    check_eq("other_valid", valid_cnt, start + 2);
    step();
    io_rd = 1'b0;

    // Sign-extended byte with a glitchy button
    switch_input = 16'h8F00;
    repeat (3) step();
    io_rd   = 1'b1;
    address = 32'hFFFF_FFF3;
    exp_q.push_back(32'hFFFF_FF8F);
    step();
    confirm_btn = 1'b1;
    step();
    confirm_btn = 1'b0;
    step();
    confirm_btn = 1'b1;
    wait_valid("sw8s", 40);
    @(negedge clk);
    check_eq("sw8s_one_cycle", 32'(rd_valid), 32'd0);
    check_eq("sw8s_restall", 32'(stall), 32'd1);
    step();
    io_rd       = 1'b0;
    confirm_btn = 1'b0;
    repeat (12) step();

    // Back-to-back loads: one press cannot serve both
    switch_input = 16'hBEEF;
    repeat (3) step();
    io_rd   = 1'b1;
    address = 32'hFFFF_FFF1;
    exp_q.push_back(32'h0000_BEEF);
    step();
    confirm_btn = 1'b1;
    wait_valid("sw16", 40);
    step();
    address      = 32'hFFFF_FFF7;
    switch_input = 16'h0006;
    exp_q.push_back(32'h0000_0006);
    start = valid_cnt;
    repeat (15) step();
    @(negedge clk);
    #1;
    check_eq("held_no_valid", valid_cnt, start);
    check_eq("held_stall", 32'(stall), 32'd1);
    step();
    confirm_btn = 1'b0;
    repeat (10) step();
    check_eq("released_no_valid", valid_cnt, start);
    confirm_btn = 1'b1;
    wait_valid("sw3", 40);
    step();
    io_rd       = 1'b0;
    confirm_btn = 1'b0;
    repeat (12) step();

    // Flush while waiting for a press
    io_rd   = 1'b1;
    address = 32'hFFFF_FFF5;
    repeat (3) step();
    @(negedge clk);
    check_eq("flush_led_on", 32'(wait_led), 32'd1);
    check_eq("flush_stall_on", 32'(stall), 32'd1);
    step();
    io_rd = 1'b0;
    step();
    @(negedge clk);
    check_eq("flush_led_off", 32'(wait_led), 32'd0);
    check_eq("flush_stall_off", 32'(stall), 32'd0);
    start = valid_cnt;
    step();
    confirm_btn = 1'b1;
    repeat (12) step();
    check_eq("flush_press_no_valid", valid_cnt, start);
    confirm_btn = 1'b0;
    repeat (12) step();

    // Reset while waiting, then a fresh low-byte load
    switch_input = 16'h12F0;
    io_rd        = 1'b1;
    address      = 32'hFFFF_FFF1;
    repeat (3) step();
    @(negedge clk);
    check_eq("midrst_led_on", 32'(wait_led), 32'd1);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_stall", 32'(stall), 32'd0);
    step();
    rst   = 1'b1;
    io_rd = 1'b0;
    @(negedge clk);
    check_eq("midrst_led_off", 32'(wait_led), 32'd0);
    step();
    step();
    io_rd   = 1'b1;
    address = 32'hFFFF_FFF9;
    exp_q.push_back(32'h0000_00F0);
    step();
    confirm_btn = 1'b1;
    wait_valid("swlo", 40);
    step();
    io_rd       = 1'b0;
    confirm_btn = 1'b0;
    repeat (5) step();
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
